core_featuremap_pointwise_mc: RTL

Parametrised multi-channel feature-map core computing one output channel of a 1x1 (pointwise) convolution in signed fixed point. Sits between `CH` show-ahead input FIFOs (one per input channel) and one output FIFO inside the VIP core. Pops all input FIFOs in lockstep, multiplies each sample by a runtime-loadable per-channel weight, sums with a bias, rounds, saturates and pushes the result. Honours output `ff_full` back-pressure through a stall-all pipeline and counts saturation events.

---
 rtl/vip_conv_pkg.sv | 30 +++
 rtl/core_featuremap_pointwise_mc_if.sv | 25 ++
 rtl/conv_round_sat.sv | 36 +++
 rtl/core_featuremap_pointwise_mc.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vip_conv_pkg.sv
// Shared Q-format helpers for the VIP convolution cores: rounding/saturation
// constants and the accumulator width used by the pointwise datapath.
package vip_conv_pkg;

    // Accumulator width: full products, headroom for CH-way sum, one bit for bias.
    function automatic int acc_width(input int dwidth, input int ch);
        return 2 * dwidth + $clog2(ch) + 1;
    endfunction

    // Q-format 1.0 for the given fractional width.
    function automatic longint q_one(input int frac);
        return longint'(1) <<< frac;
    endfunction

    // Half an output LSB at the accumulator scale (round half up).
    function automatic longint ROUND_HALF(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    // Largest representable result.
    function automatic longint SAT_MAX(input int dwidth);
        return (longint'(1) <<< (dwidth - 1)) - 1;
    endfunction

    // Most negative representable result.
    function automatic longint SAT_MIN(input int dwidth);
        return -(longint'(1) <<< (dwidth - 1));
    endfunction

endpackage

// File: rtl/core_featuremap_pointwise_mc_if.sv
// FIFO-side bundle of the pointwise core: CH show-ahead input heads with a
// common pop, and one output FIFO push port.
interface core_featuremap_pointwise_mc_if #(
    parameter int DWIDTH = 32,
    parameter int CH     = 8
);
    logic [CH*DWIDTH-1:0] ff_rdata;
    logic [CH-1:0]        ff_empty;
    logic                 ff_rdreq;
    logic [DWIDTH-1:0]    ff_wdata;
    logic                 ff_wrreq;
    logic                 ff_full;

    // FIFO side: supplies heads/status, receives strobes and result.
    modport master (
        output ff_rdata, ff_empty, ff_full,
        input  ff_rdreq, ff_wdata, ff_wrreq
    );

    // Core side.
    modport slave (
        input  ff_rdata, ff_empty, ff_full,
        output ff_rdreq, ff_wdata, ff_wrreq
    );
endinterface

// File: rtl/conv_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and saturation from
// the accumulator width down to DWIDTH, with a saturation flag.
module conv_round_sat
    import vip_conv_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 16,
    parameter int ACC_W  = 68
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DWIDTH-1:0] res,
    output logic                     sat
);
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(ROUND_HALF(FRAC));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(SAT_MAX(DWIDTH));
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(SAT_MIN(DWIDTH));

    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        return (a + RND) >>> FRAC;
    endfunction

    function automatic logic signed [DWIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > MAXV) return MAXV[DWIDTH-1:0];
        else if (v < MINV) return MINV[DWIDTH-1:0];
        else return v[DWIDTH-1:0];
    endfunction

    logic signed [ACC_W-1:0] shifted;

    // Round, rescale and clip the accumulator into the output Q format.
    always_comb begin
        shifted = round_shift(acc);
        res     = saturate(shifted);
        sat     = (shifted > MAXV) || (shifted < MINV);
    end
endmodule

// File: rtl/core_featuremap_pointwise_mc.sv
// One output channel of a 1x1 convolution over CH input channels.
// Three-stage stall-all pipeline: products, bias-sum, round/saturate.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
module core_featuremap_pointwise_mc
    import vip_conv_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CH     = 8,
    parameter int FRAC   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    core_featuremap_pointwise_mc_if.slave bus,
    input  logic                     cfg_we,
    input  logic [$clog2(CH+1)-1:0]  cfg_addr,
    input  logic [DWIDTH-1:0]        cfg_wdata,
    output logic [15:0]              sat_cnt
);
    localparam int AW    = $clog2(CH + 1);
    localparam int PW    = 2 * DWIDTH;
    localparam int ACC_W = acc_width(DWIDTH, CH);
    localparam logic signed [DWIDTH-1:0] W_ONE = DWIDTH'(q_one(FRAC));

    logic signed [DWIDTH-1:0] weight [CH];
    logic signed [DWIDTH-1:0] bias;
    logic signed [DWIDTH-1:0] x [CH];

    logic                     stall;
    logic                     pop;
    logic                     wrreq;

    logic signed [PW-1:0]     prod_p1 [CH];
    logic signed [DWIDTH-1:0] bias_p1;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  sum_p1;

    logic signed [ACC_W-1:0]  acc_p2;
    logic                     vld_p2;

    logic signed [DWIDTH-1:0] res_sat;
    logic signed [DWIDTH-1:0] res_out;
    logic                     sat_flag;

    logic [DWIDTH-1:0]        wdata_p3;
    logic                     vld_p3;
    logic                     sat_p3;

    // Unpack the input FIFO heads into signed per-channel samples.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            x[k] = bus.ff_rdata[k*DWIDTH +: DWIDTH];
        end
    end

    // A held S3 word freezes the whole pipe; all channels pop together or not at all.
    assign stall        = vld_p3 & bus.ff_full;
    assign pop          = ~reset & ~(|bus.ff_empty) & ~stall;
    assign wrreq        = vld_p3 & ~bus.ff_full;
    assign bus.ff_rdreq = pop;
    assign bus.ff_wrreq = wrreq;
    assign bus.ff_wdata = wdata_p3;

    // Coefficient store: weights k=0..CH-1, bias at address CH, others ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < CH; k++) weight[k] <= W_ONE;
            bias <= '0;
        end else if (cfg_we) begin
            for (int k = 0; k < CH; k++) begin
                if (cfg_addr == AW'(k)) weight[k] <= cfg_wdata;
            end
            if (cfg_addr == AW'(CH)) bias <= cfg_wdata;
        end
    end

    // ---- S1: per-channel products, bias captured with the sample ----
    // S1 valid tracks accepted pops.
    always_ff @(posedge clock) begin
        if (reset) vld_p1 <= 1'b0;
        else if (!stall) vld_p1 <= pop;
    end

    // S1 data: full-width signed products.
    always_ff @(posedge clock) begin
        if (!stall) begin
            for (int k = 0; k < CH; k++) begin
                prod_p1[k] <= PW'(x[k]) * PW'(weight[k]);
            end
            bias_p1 <= bias;
        end
    end

    // Sum of products plus bias aligned to the product scale.
    always_comb begin
        sum_p1 = ACC_W'(bias_p1) <<< FRAC;
        for (int k = 0; k < CH; k++) begin
            sum_p1 = sum_p1 + ACC_W'(prod_p1[k]);
        end
    end

    // ---- S2: wide accumulator ----
    // S2 valid follows S1 unless stalled.
    always_ff @(posedge clock) begin
        if (reset) vld_p2 <= 1'b0;
        else if (!stall) vld_p2 <= vld_p1;
    end

    // S2 data: registered accumulator.
    always_ff @(posedge clock) begin
        if (!stall) acc_p2 <= sum_p1;
    end

    conv_round_sat #(
        .DWIDTH (DWIDTH),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
    ) u_round_sat (
        .acc (acc_p2),
        .res (res_sat),
        .sat (sat_flag)
    );

    // Optional ReLU after saturation; it never raises the saturation flag itself.
    always_comb begin
`ifdef CONV_RELU_EN
        res_out = res_sat[DWIDTH-1] ? '0 : res_sat;
`else
        res_out = res_sat;
`endif
    end

    // ---- S3: output word, held while the output FIFO is full ----
    // S3 register carries the pushed word; it resets to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p3   <= 1'b0;
            wdata_p3 <= '0;
            sat_p3   <= 1'b0;
        end else if (!stall) begin
            vld_p3   <= vld_p2;
            wdata_p3 <= res_out;
            sat_p3   <= sat_flag;
        end
    end

    // Count pushed saturated words, sticking at all-ones.
    always_ff @(posedge clock) begin
        if (reset) sat_cnt <= '0;
        else if (wrreq && sat_p3 && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
endmodule
